// File: rtl/int_ctrl_if.sv
// CPU-side interrupt handshake bundle.
//   master (CPU)       : drives gie, ie, int_ack, int_done; observes the rest
//   slave  (int_ctrl)  : drives int_req, int_vector, pending, active
interface int_ctrl_if;
    localparam int unsigned VEC_W = 10;
    localparam int unsigned SRC_N = 3;

    logic             gie;
    logic [SRC_N-1:0] ie;
    logic             int_ack;
    logic             int_done;
    logic             int_req;
    logic [VEC_W-1:0] int_vector;
    logic [SRC_N-1:0] pending;
    logic [1:0]       active;

    modport master (
        output gie, ie, int_ack, int_done,
        input  int_req, int_vector, pending, active
    );

    modport slave (
        input  gie, ie, int_ack, int_done,
        output int_req, int_vector, pending, active
    );
endinterface

// File: rtl/int_ctrl.sv
// Three-source prioritised interrupt controller (EI > T0 > T1).
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   ext_int         : asynchronous external interrupt line (synchronised here)
//   t0_done/t1_done : timer done levels, held until acknowledged
//   t0_ack/t1_ack   : one-cycle acknowledge pulses back to the timers
//   bus             : CPU handshake (gie, ie, int_ack, int_done in;
//                     int_req, int_vector, pending, active out)
module int_ctrl #(
    parameter logic [9:0] VEC_EI = 10'h010,
    parameter logic [9:0] VEC_T0 = 10'h020,
    parameter logic [9:0] VEC_T1 = 10'h030
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_int,
    input  logic       t0_done,
    input  logic       t1_done,
    output logic       t0_ack,
    output logic       t1_ack,
    int_ctrl_if.slave  bus
);
    localparam int unsigned VEC_W = 10;
    localparam int unsigned SRC_N = 3;

    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EI   = 2'd1,
        SRC_T0   = 2'd2,
        SRC_T1   = 2'd3
    } src_t;

    state_t           state;
    src_t             src_q;
    src_t             active_q;
    src_t             win_c;
    logic [VEC_W-1:0] win_vec_c;
    logic [VEC_W-1:0] vec_q;
    logic             int_req_q;
    logic             t0_ack_q;
    logic             t1_ack_q;
    logic [SRC_N-1:0] pending_q;
    logic [SRC_N-1:0] set_c;
    logic [SRC_N-1:0] clr_c;
    logic [SRC_N-1:0] masked_c;
    logic [SRC_N-1:0] src_bit_c;

    // ext_int synchroniser plus a valid chain so that reset-time zeros in the
    // synchroniser are never mistaken for a real low level.
    logic ei_s1, ei_s2, ei_v1, ei_v2;
    // Edge detect: "last valid sample was low". Cleared by reset, so a line
    // already high at reset release must drop before it can fire again.
    logic ei_low_q, t0_low_q, t1_low_q;

    // Rising-edge set requests, in pending bit order
    always_comb begin
        set_c = {ei_s2 & ei_low_q, t0_done & t0_low_q, t1_done & t1_low_q};
    end

    // Fixed-priority winner among enabled pending sources
    always_comb begin
        masked_c  = pending_q & bus.ie;
        win_c     = SRC_NONE;
        win_vec_c = VEC_EI;
        if (masked_c[2]) begin
            win_c     = SRC_EI;
            win_vec_c = VEC_EI;
        end else if (masked_c[1]) begin
            win_c     = SRC_T0;
            win_vec_c = VEC_T0;
        end else if (masked_c[0]) begin
            win_c     = SRC_T1;
            win_vec_c = VEC_T1;
        end
    end

    // One-hot pending/ie position of the latched source
    always_comb begin
        case (src_q)
            SRC_EI:  src_bit_c = 3'b100;
            SRC_T0:  src_bit_c = 3'b010;
            SRC_T1:  src_bit_c = 3'b001;
            default: src_bit_c = 3'b000;
        endcase
    end

    // Pending clear on acceptance; set still wins in the merge below
    always_comb begin
        clr_c = (state == REQUEST && bus.int_ack) ? src_bit_c : 3'b000;
    end

    // Synchroniser and edge-detect flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ei_s1    <= 1'b0;
            ei_s2    <= 1'b0;
            ei_v1    <= 1'b0;
            ei_v2    <= 1'b0;
            ei_low_q <= 1'b0;
            t0_low_q <= 1'b0;
            t1_low_q <= 1'b0;
        end else begin
            ei_s1    <= ext_int;
            ei_s2    <= ei_s1;
            ei_v1    <= 1'b1;
            ei_v2    <= ei_v1;
            ei_low_q <= ei_v2 & ~ei_s2;
            t0_low_q <= ~t0_done;
            t1_low_q <= ~t1_done;
        end
    end

    // Request/service state machine with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            src_q     <= SRC_NONE;
            active_q  <= SRC_NONE;
            int_req_q <= 1'b0;
            vec_q     <= '0;
            t0_ack_q  <= 1'b0;
            t1_ack_q  <= 1'b0;
            pending_q <= '0;
        end else begin
            t0_ack_q  <= 1'b0;
            t1_ack_q  <= 1'b0;
            pending_q <= (pending_q & ~clr_c) | set_c;
            case (state)
                IDLE: begin
                    if (bus.gie && win_c != SRC_NONE) begin
                        state     <= REQUEST;
                        src_q     <= win_c;
                        int_req_q <= 1'b1;
                        vec_q     <= win_vec_c;
                    end
                end
                REQUEST: begin
                    // Acceptance outranks a same-cycle withdrawal
                    if (bus.int_ack) begin
                        state     <= SERVICE;
                        int_req_q <= 1'b0;
                        active_q  <= src_q;
                        t0_ack_q  <= (src_q == SRC_T0);
                        t1_ack_q  <= (src_q == SRC_T1);
                    end else if (!bus.gie || (src_bit_c & bus.ie) == 3'b000) begin
                        state     <= IDLE;
                        int_req_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (bus.int_done) begin
                        state    <= IDLE;
                        active_q <= SRC_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign t0_ack         = t0_ack_q;
    assign t1_ack         = t1_ack_q;
    assign bus.int_req    = int_req_q;
    assign bus.int_vector = vec_q;
    assign bus.pending    = pending_q;
    assign bus.active     = active_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed stimulus with request/ack scoreboards.
module tb_int_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ext_int = 1'b0;
    logic t0_done = 1'b0;
    logic t1_done = 1'b0;
    logic t0_ack;
    logic t1_ack;

    int_ctrl_if bus ();

    int_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .ext_int (ext_int),
        .t0_done (t0_done),
        .t1_done (t1_done),
        .t0_ack  (t0_ack),
        .t1_ack  (t1_ack),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [9:0] req_q[$];   // expected vectors, in request order
    logic [1:0] ack_q[$];   // expected {t1_ack, t0_ack} pulses, in order

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every new request and every ack pulse consumes an entry
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (rst && bus.int_req && !req_prev) begin
            check("sb_req_avail", 32'(req_q.size() > 0), 32'd1);
            if (req_q.size() > 0) check("req_vector", 32'(bus.int_vector), 32'(req_q.pop_front()));
        end
        if (rst && (t0_ack || t1_ack)) begin
            check("sb_ack_avail", 32'(ack_q.size() > 0), 32'd1);
            if (ack_q.size() > 0) check("ack_pulse", 32'({t1_ack, t0_ack}), 32'(ack_q.pop_front()));
        end
        req_prev = bus.int_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_req();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.int_req) got = 1'b1;
            else step();
        end
        check("req_seen", 32'(got), 32'd1);
    endtask

    task automatic serve(input logic [1:0] exp_active, input logic [1:0] exp_ack);
        wait_req();
        if (exp_ack != 2'b00) ack_q.push_back(exp_ack);
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        check("svc_active", 32'(bus.active), 32'(exp_active));
        check("svc_req_low", 32'(bus.int_req), 32'd0);
        steps(2);
        bus.int_done = 1'b1;
        step();
        bus.int_done = 1'b0;
        check("done_active", 32'(bus.active), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.gie = 1'b0;
        bus.ie = 3'b000;
        bus.int_ack = 1'b0;
        bus.int_done = 1'b0;

        // Reset values
        #2;
        check("rst_req", 32'(bus.int_req), 32'd0);
        check("rst_vec", 32'(bus.int_vector), 32'd0);
        check("rst_pend", 32'(bus.pending), 32'd0);
        check("rst_active", 32'(bus.active), 32'd0);
        check("rst_acks", 32'({t1_ack, t0_ack}), 32'd0);
        steps(2);
        rst = 1'b1;
        steps(3);

        // Timer 0 basic flow with exact timing
        bus.gie = 1'b1;
        bus.ie = 3'b111;
        req_q.push_back(10'h020);
        t0_done = 1'b1;
        step();
        check("t0_pend", 32'(bus.pending), 32'h2);
        check("t0_req_early", 32'(bus.int_req), 32'd0);
        step();
        check("t0_req", 32'(bus.int_req), 32'd1);
        check("t0_vec", 32'(bus.int_vector), 32'h020);
        ack_q.push_back(2'b01);
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        check("t0_ack_hi", 32'(t0_ack), 32'd1);
        check("t0_active", 32'(bus.active), 32'd2);
        check("t0_pend_clr", 32'(bus.pending), 32'd0);
        check("t0_req_drop", 32'(bus.int_req), 32'd0);
        step();
        check("t0_ack_lo", 32'(t0_ack), 32'd0);
        check("t0_held_no_reset", 32'(bus.pending), 32'd0);
        t0_done = 1'b0;
        bus.int_done = 1'b1;
        step();
        bus.int_done = 1'b0;
        check("t0_done_active", 32'(bus.active), 32'd0);
        check("vec_hold", 32'(bus.int_vector), 32'h020);

        // Simultaneous EI and T1 (latched while disabled): EI first, then T1
        bus.gie = 1'b0;
        ext_int = 1'b1;
        t1_done = 1'b1;
        steps(4);
        check("both_pend", 32'(bus.pending), 32'h5);
        check("masked_no_req", 32'(bus.int_req), 32'd0);
        req_q.push_back(10'h010);
        req_q.push_back(10'h030);
        bus.gie = 1'b1;
        serve(2'd1, 2'b00);
        serve(2'd3, 2'b10);
        t1_done = 1'b0;
        ext_int = 1'b0;
        steps(3);

        // Winner stays latched when EI arrives during T1 request
        req_q.push_back(10'h030);
        req_q.push_back(10'h010);
        t1_done = 1'b1;
        wait_req();
        ext_int = 1'b1;
        steps(4);
        check("latched_vec", 32'(bus.int_vector), 32'h030);
        check("latched_pend", 32'(bus.pending), 32'h5);
        serve(2'd3, 2'b10);
        t1_done = 1'b0;
        serve(2'd1, 2'b00);
        ext_int = 1'b0;
        steps(3);

        // gie=0 latches pending without request; enabling requests next cycle
        bus.gie = 1'b0;
        t0_done = 1'b1;
        steps(3);
        check("gie0_pend", 32'(bus.pending), 32'h2);
        check("gie0_noreq", 32'(bus.int_req), 32'd0);
        req_q.push_back(10'h020);
        bus.gie = 1'b1;
        step();
        check("gie1_req", 32'(bus.int_req), 32'd1);
        serve(2'd2, 2'b01);
        t0_done = 1'b0;
        steps(2);

        // Withdrawal by gie drop, then reissue
        req_q.push_back(10'h030);
        req_q.push_back(10'h030);
        t1_done = 1'b1;
        wait_req();
        bus.gie = 1'b0;
        step();
        check("wd_req_low", 32'(bus.int_req), 32'd0);
        check("wd_pend_kept", 32'(bus.pending), 32'h1);
        step();
        check("wd_stays_low", 32'(bus.int_req), 32'd0);
        bus.gie = 1'b1;
        step();
        check("wd_reissue", 32'(bus.int_req), 32'd1);
        serve(2'd3, 2'b10);
        t1_done = 1'b0;
        steps(2);

        // Withdrawal by clearing the latched source's enable
        req_q.push_back(10'h020);
        req_q.push_back(10'h020);
        t0_done = 1'b1;
        wait_req();
        bus.ie = 3'b101;
        step();
        check("ie_wd_req_low", 32'(bus.int_req), 32'd0);
        check("ie_wd_pend", 32'(bus.pending), 32'h2);
        bus.ie = 3'b111;
        serve(2'd2, 2'b01);
        t0_done = 1'b0;
        steps(2);

        // int_ack wins over same-cycle gie drop
        req_q.push_back(10'h020);
        ack_q.push_back(2'b01);
        t0_done = 1'b1;
        wait_req();
        bus.gie = 1'b0;
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        check("ack_race_active", 32'(bus.active), 32'd2);
        t0_done = 1'b0;
        bus.gie = 1'b1;
        bus.int_done = 1'b1;
        step();
        bus.int_done = 1'b0;
        check("ack_race_done", 32'(bus.active), 32'd0);

        // Stray handshakes in IDLE are ignored
        bus.int_ack = 1'b1;
        bus.int_done = 1'b1;
        steps(2);
        bus.int_ack = 1'b0;
        bus.int_done = 1'b0;
        check("stray_active", 32'(bus.active), 32'd0);
        check("stray_req", 32'(bus.int_req), 32'd0);

        // Reset in SERVICE aborts asynchronously; held lines give no request
        req_q.push_back(10'h010);
        ext_int = 1'b1;
        wait_req();
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        check("pre_rst_active", 32'(bus.active), 32'd1);
        t0_done = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check("arst_active", 32'(bus.active), 32'd0);
        check("arst_req", 32'(bus.int_req), 32'd0);
        check("arst_vec", 32'(bus.int_vector), 32'd0);
        check("arst_pend", 32'(bus.pending), 32'd0);
        steps(2);
        rst = 1'b1;
        steps(10);
        check("held_no_pend", 32'(bus.pending), 32'd0);
        check("held_no_req", 32'(bus.int_req), 32'd0);
        t0_done = 1'b0;
        ext_int = 1'b0;
        steps(4);

        // A fresh edge after reset is serviced normally
        req_q.push_back(10'h010);
        ext_int = 1'b1;
        serve(2'd1, 2'b00);
        ext_int = 1'b0;
        steps(5);

        check("req_q_drain", 32'(req_q.size()), 32'd0);
        check("ack_q_drain", 32'(ack_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
